// File: rtl/trng_pkg.sv
// Shared constants, FSM encoding and word-slot mapping for the TRNG block path.
// The serializer and the assembler both use slot_lsb so the two ends agree on word order.
package trng_pkg;

  localparam int WORD_W  = 32;
  localparam int WORDS   = 16;
  localparam int BLOCK_W = WORD_W * WORDS;
  localparam int SLOT_W  = $clog2(WORDS);
  localparam int CNT_W   = $clog2(WORDS + 1);
  localparam int LSB_W   = $clog2(BLOCK_W);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // Word 0 lands in the top bits of the block, word WORDS-1 in the bottom bits.
  function automatic logic [LSB_W-1:0] slot_lsb(input logic [SLOT_W-1:0] slot);
    slot_lsb = LSB_W'(BLOCK_W - WORD_W * (int'(slot) + 1));
  endfunction

endpackage

// File: rtl/trng_gap_timer.sv
// Counts consecutive idle cycles inside a partial block and pulses expired on the
// cycle that completes GAP_LIMIT of them. GAP_LIMIT=0 disables the timeout.
module trng_gap_timer #(
  parameter int GAP_LIMIT = 4
) (
  input  logic SCLK,
  input  logic RST,
  input  logic clear,
  input  logic tick,
  input  logic enable,
  output logic expired
);

  localparam int CW = (GAP_LIMIT > 0) ? $clog2(GAP_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(GAP_LIMIT);

  logic [CW-1:0] gap_cnt_r;

  // Saturating idle-cycle counter, reset whenever a word arrives or timing is disabled.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      gap_cnt_r <= {CW{1'b0}};
    end else if (clear || !enable) begin
      gap_cnt_r <= {CW{1'b0}};
    end else if (tick && (gap_cnt_r != LIMIT_C)) begin
      gap_cnt_r <= gap_cnt_r + CW'(1);
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

  generate
    if (GAP_LIMIT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = enable && tick && !clear && (gap_cnt_r == CW'(GAP_LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/trng_block_assembler.sv
// Reassembles a stream of 32-bit random words into 512-bit blocks and holds each
// finished block for a downstream consumer under a valid/ack handshake.
module trng_block_assembler
  import trng_pkg::*;
#(
  parameter int GAP_LIMIT = 4
) (
  input  logic               SCLK,
  input  logic               RST,
  input  logic               WORD_VALID,
  input  logic [WORD_W-1:0]  WORD_DATA,
  input  logic               BLOCK_ACK,
  output logic [BLOCK_W-1:0] BLOCK_DATA,
  output logic               BLOCK_VALID,
  output logic [CNT_W-1:0]   WORD_COUNT,
  output logic               ABORT,
  output logic               OVERRUN
);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [BLOCK_W-1:0] block_r;
  logic [BLOCK_W-1:0] block_nxt_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt_s;
  logic               valid_r;
  logic               valid_nxt_s;
  logic               abort_r;
  logic               abort_nxt_s;
  logic               overrun_r;
  logic               overrun_nxt_s;
  logic               expired_s;
  logic [LSB_W-1:0]   wr_lsb_s;
  logic [LSB_W-1:0]   slot0_lsb_s;

  trng_gap_timer #(
    .GAP_LIMIT(GAP_LIMIT)
  ) u_gap_timer (
    .SCLK   (SCLK),
    .RST    (RST),
    .clear  (WORD_VALID),
    .tick   (!WORD_VALID),
    .enable (state_r == ST_COLLECT),
    .expired(expired_s)
  );

  assign wr_lsb_s    = slot_lsb(count_r[SLOT_W-1:0]);
  assign slot0_lsb_s = slot_lsb({SLOT_W{1'b0}});

  // Next-state, packing and flag logic for the IDLE/COLLECT/FULL handshake.
  always_comb begin
    state_nxt_s   = state_r;
    block_nxt_s   = block_r;
    count_nxt_s   = count_r;
    valid_nxt_s   = valid_r;
    abort_nxt_s   = 1'b0;
    overrun_nxt_s = overrun_r;
    case (state_r)
      ST_IDLE: begin
        if (WORD_VALID) begin
          block_nxt_s[slot0_lsb_s +: WORD_W] = WORD_DATA;
          count_nxt_s = CNT_W'(1);
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (WORD_VALID) begin
          block_nxt_s[wr_lsb_s +: WORD_W] = WORD_DATA;
          count_nxt_s = count_r + CNT_W'(1);
          if (count_r == CNT_W'(WORDS - 1)) begin
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_COLLECT;
          end
        end else if (expired_s) begin
          block_nxt_s = {BLOCK_W{1'b0}};
          count_nxt_s = {CNT_W{1'b0}};
          abort_nxt_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_FULL: begin
        if (BLOCK_ACK) begin
          valid_nxt_s = 1'b0;
          if (WORD_VALID) begin
            // Release and restart in one edge so a word arriving with the ack is kept.
            block_nxt_s[slot0_lsb_s +: WORD_W] = WORD_DATA;
            count_nxt_s = CNT_W'(1);
            state_nxt_s = ST_COLLECT;
          end else begin
            count_nxt_s = {CNT_W{1'b0}};
            state_nxt_s = ST_IDLE;
          end
        end else if (WORD_VALID) begin
          overrun_nxt_s = 1'b1;
          state_nxt_s   = ST_FULL;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        block_nxt_s = {BLOCK_W{1'b0}};
        count_nxt_s = {CNT_W{1'b0}};
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      block_r   <= {BLOCK_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      valid_r   <= 1'b0;
      abort_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      block_r   <= block_nxt_s;
      count_r   <= count_nxt_s;
      valid_r   <= valid_nxt_s;
      abort_r   <= abort_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  assign BLOCK_DATA  = block_r;
  assign BLOCK_VALID = valid_r;
  assign WORD_COUNT  = count_r;
  assign ABORT       = abort_r;
  assign OVERRUN     = overrun_r;

endmodule

// File: tb/tb_trng_block_assembler.sv
// Directed bench for trng_block_assembler: a GAP_LIMIT=4 instance and a GAP_LIMIT=0
// instance share the stimulus; each test resets both before it starts.
module tb_trng_block_assembler;

  logic         SCLK = 1'b0;
  logic         RST = 1'b1;
  logic         WORD_VALID = 1'b0;
  logic [31:0]  WORD_DATA = 32'h0;
  logic         BLOCK_ACK = 1'b0;

  logic [511:0] blk_a, blk_z;
  logic         valid_a, valid_z;
  logic [4:0]   cnt_a, cnt_z;
  logic         abort_a, abort_z;
  logic         ovr_a, ovr_z;

  int n_vec = 0;
  int n_err = 0;
  int abort_cnt_a = 0;
  int abort_cnt_z = 0;
  logic [511:0] exp_blk;
  logic [511:0] hold_blk;

  trng_block_assembler #(.GAP_LIMIT(4)) dut (
    .SCLK(SCLK), .RST(RST), .WORD_VALID(WORD_VALID), .WORD_DATA(WORD_DATA),
    .BLOCK_ACK(BLOCK_ACK), .BLOCK_DATA(blk_a), .BLOCK_VALID(valid_a),
    .WORD_COUNT(cnt_a), .ABORT(abort_a), .OVERRUN(ovr_a)
  );

  trng_block_assembler #(.GAP_LIMIT(0)) dut0 (
    .SCLK(SCLK), .RST(RST), .WORD_VALID(WORD_VALID), .WORD_DATA(WORD_DATA),
    .BLOCK_ACK(BLOCK_ACK), .BLOCK_DATA(blk_z), .BLOCK_VALID(valid_z),
    .WORD_COUNT(cnt_z), .ABORT(abort_z), .OVERRUN(ovr_z)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge SCLK);
    #1;
    if (abort_a === 1'b1) abort_cnt_a++;
    if (abort_z === 1'b1) abort_cnt_z++;
  endtask

  task automatic send_word(input logic [31:0] d);
    WORD_VALID = 1'b1;
    WORD_DATA  = d;
    step();
    WORD_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    WORD_VALID = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    WORD_VALID = 1'b1;
    BLOCK_ACK  = 1'b1;
    step();
    RST = 1'b0;
    WORD_VALID = 1'b0;
    BLOCK_ACK  = 1'b0;
  endtask

  // Sends words base+first .. base+last and records them in exp_blk.
  task automatic send_range(input logic [31:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      exp_blk[511 - 32*i -: 32] = base + 32'(i);
      send_word(base + 32'(i));
    end
  endtask

  initial begin
    // Reset with random inputs on both edges.
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      WORD_VALID = 1'($urandom_range(0, 1));
      WORD_DATA  = $urandom;
      BLOCK_ACK  = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_data",    blk_a, 512'h0);
    chk("rst_valid",   {511'h0, valid_a}, 512'h0);
    chk("rst_count",   {507'h0, cnt_a}, 512'h0);
    chk("rst_abort",   {511'h0, abort_a}, 512'h0);
    chk("rst_overrun", {511'h0, ovr_a}, 512'h0);
    RST = 1'b0; WORD_VALID = 1'b0; BLOCK_ACK = 1'b0;

    // Reset after 8 words.
    exp_blk = 512'h0;
    send_range(32'hC0DE0000, 0, 7);
    chk("mid_count8", {507'h0, cnt_a}, 512'd8);
    do_reset();
    chk("mid_rst_count", {507'h0, cnt_a}, 512'h0);
    chk("mid_rst_data",  blk_a, 512'h0);

    // Clean block 0x0..0xF, one-edge latency to BLOCK_VALID, held without ack.
    exp_blk = 512'h0;
    send_range(32'h0, 0, 14);
    chk("pre_full_valid", {511'h0, valid_a}, 512'h0);
    chk("pre_full_count", {507'h0, cnt_a}, 512'd15);
    send_range(32'h0, 15, 15);
    chk("full_valid", {511'h0, valid_a}, 512'h1);
    chk("full_count", {507'h0, cnt_a}, 512'd16);
    chk("full_top",   {480'h0, blk_a[511:480]}, 512'h0);
    chk("full_bot",   {480'h0, blk_a[31:0]}, 512'hF);
    chk("full_data",  blk_a, exp_blk);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_data",  blk_a, exp_blk);
      chk("hold_valid", {511'h0, valid_a}, 512'h1);
    end
    BLOCK_ACK = 1'b1;
    step();
    BLOCK_ACK = 1'b0;
    chk("ack_valid", {511'h0, valid_a}, 512'h0);
    chk("ack_count", {507'h0, cnt_a}, 512'h0);
    chk("ack_data_kept", blk_a, exp_blk);

    // Three idle cycles mid-block never abort.
    do_reset();
    abort_cnt_a = 0;
    exp_blk = 512'h0;
    send_range(32'h100, 0, 4);
    idle(3);
    chk("gap3_count", {507'h0, cnt_a}, 512'd5);
    send_range(32'h100, 5, 15);
    chk("gap3_aborts", 512'(abort_cnt_a), 512'h0);
    chk("gap3_valid",  {511'h0, valid_a}, 512'h1);
    chk("gap3_data",   blk_a, exp_blk);

    // Four idle cycles abort with a single-cycle pulse.
    do_reset();
    abort_cnt_a = 0;
    exp_blk = 512'h0;
    send_range(32'h200, 0, 4);
    idle(3);
    chk("gap4_pre_abort", {511'h0, abort_a}, 512'h0);
    idle(1);
    chk("gap4_abort", {511'h0, abort_a}, 512'h1);
    chk("gap4_count", {507'h0, cnt_a}, 512'h0);
    chk("gap4_data",  blk_a, 512'h0);
    chk("gap4_valid", {511'h0, valid_a}, 512'h0);
    idle(1);
    chk("gap4_pulse_end", {511'h0, abort_a}, 512'h0);
    chk("gap4_abort_total", 512'(abort_cnt_a), 512'h1);
    send_word(32'h13572468);
    chk("post_abort_count", {507'h0, cnt_a}, 512'd1);
    chk("post_abort_slot0", {480'h0, blk_a[511:480]}, {480'h0, 32'h13572468});

    // Overrun while a block is held; sticky until reset.
    do_reset();
    exp_blk = 512'h0;
    send_range(32'h1000, 0, 15);
    chk("ovr_pre", {511'h0, ovr_a}, 512'h0);
    send_word(32'hDEADBEEF);
    chk("ovr_set",   {511'h0, ovr_a}, 512'h1);
    chk("ovr_data",  blk_a, exp_blk);
    chk("ovr_count", {507'h0, cnt_a}, 512'd16);
    chk("ovr_valid", {511'h0, valid_a}, 512'h1);
    BLOCK_ACK = 1'b1;
    step();
    BLOCK_ACK = 1'b0;
    idle(3);
    chk("ovr_sticky",      {511'h0, ovr_a}, 512'h1);
    chk("ovr_ack_valid",   {511'h0, valid_a}, 512'h0);
    do_reset();
    chk("ovr_rst", {511'h0, ovr_a}, 512'h0);

    // Ack and word on the same edge: block released, word starts the next block.
    exp_blk = 512'h0;
    send_range(32'h2000, 0, 15);
    hold_blk = {32'hA5A5A5A5, exp_blk[479:0]};
    WORD_VALID = 1'b1; WORD_DATA = 32'hA5A5A5A5; BLOCK_ACK = 1'b1;
    step();
    WORD_VALID = 1'b0; BLOCK_ACK = 1'b0;
    chk("sim_valid",   {511'h0, valid_a}, 512'h0);
    chk("sim_count",   {507'h0, cnt_a}, 512'd1);
    chk("sim_top",     {480'h0, blk_a[511:480]}, {480'h0, 32'hA5A5A5A5});
    chk("sim_data",    blk_a, hold_blk);
    chk("sim_overrun", {511'h0, ovr_a}, 512'h0);
    BLOCK_ACK = 1'b1;
    step();
    BLOCK_ACK = 1'b0;
    chk("ack_outside_full", {507'h0, cnt_a}, 512'd1);

    // GAP_LIMIT=0 instance ignores long gaps.
    do_reset();
    abort_cnt_z = 0;
    exp_blk = 512'h0;
    send_range(32'h3000, 0, 4);
    idle(100);
    chk("nolimit_count", {507'h0, cnt_z}, 512'd5);
    send_range(32'h3000, 5, 15);
    chk("nolimit_aborts", 512'(abort_cnt_z), 512'h0);
    chk("nolimit_valid",  {511'h0, valid_z}, 512'h1);
    chk("nolimit_data",   blk_z, exp_blk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
